image_mean_zone_sequencer: RTL and testbench

Multi-zone metering controller for the `image_mean` accumulator. It reprograms the `image_mean` window at each frame start so that successive frames measure successive zones of a grid of up to 4x4 rectangular zones. It captures the four Bayer-channel sums and the pixel count for each zone into a result store that firmware can read, then signals when a full sweep is complete. It sits beside `image_mean` on the pixclk pixel stream.

---
 rtl/image_mean_zone_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_image_mean_zone_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_mean_zone_sequencer.sv
// image_mean_zone_sequencer: steps the image_mean window across a grid of up
// to 4x4 zones, one zone per frame, and keeps the per-zone channel sums and
// pixel counts in a result store readable by firmware.
module image_mean_zone_sequencer #(
    parameter int PIXEL_WIDTH    = 8,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12,
    parameter int ACCUM_WIDTH    = NUM_ROWS_WIDTH + NUM_COLS_WIDTH + PIXEL_WIDTH - 2,
    parameter int COUNT_WIDTH    = NUM_ROWS_WIDTH + NUM_COLS_WIDTH - 2,
    parameter int DTYPE_WIDTH    = 4,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = DTYPE_WIDTH'(1)
) (
    input  logic                      pixclk,
    input  logic                      resetb,
    input  logic                      dvi,
    input  logic [DTYPE_WIDTH-1:0]    dtypei,
    input  logic                      enable,
    input  logic                      continuous,
    input  logic [1:0]                grid_rows_m1,
    input  logic [1:0]                grid_cols_m1,
    input  logic [NUM_ROWS_WIDTH-1:0] origin_row,
    input  logic [NUM_COLS_WIDTH-1:0] origin_col,
    input  logic [NUM_ROWS_WIDTH-1:0] zone_height,
    input  logic [NUM_COLS_WIDTH-1:0] zone_width,
    input  logic                      mean_done,
    input  logic [ACCUM_WIDTH-1:0]    mean_accum00,
    input  logic [ACCUM_WIDTH-1:0]    mean_accum01,
    input  logic [ACCUM_WIDTH-1:0]    mean_accum10,
    input  logic [ACCUM_WIDTH-1:0]    mean_accum11,
    input  logic [COUNT_WIDTH-1:0]    mean_count,
    output logic [NUM_ROWS_WIDTH-1:0] window_row_start,
    output logic [NUM_ROWS_WIDTH-1:0] window_row_end,
    output logic [NUM_COLS_WIDTH-1:0] window_col_start,
    output logic [NUM_COLS_WIDTH-1:0] window_col_end,
    input  logic [3:0]                rd_zone,
    input  logic [2:0]                rd_sel,
    output logic [ACCUM_WIDTH-1:0]    rd_data,
    output logic [15:0]               zone_valid,
    output logic [3:0]                cur_zone,
    output logic                      sweep_busy,
    output logic                      sweep_done,
    output logic                      error,
    input  logic                      error_clr
);

    localparam int RW = NUM_ROWS_WIDTH;
    localparam int CW = NUM_COLS_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_CAPTURE} state_t;

    // Saturating add one bit wider than the coordinate; a carry out pins to all-ones.
    function automatic logic [RW:0] row_add(input logic [RW:0] a, input logic [RW-1:0] b);
        logic [RW+1:0] s;
        s = {1'b0, a} + {2'b00, b};
        return s[RW+1] ? '1 : s[RW:0];
    endfunction

    function automatic logic [CW:0] col_add(input logic [CW:0] a, input logic [CW-1:0] b);
        logic [CW+1:0] s;
        s = {1'b0, a} + {2'b00, b};
        return s[CW+1] ? '1 : s[CW:0];
    endfunction

    function automatic logic [RW-1:0] row_clamp(input logic [RW:0] a);
        return a[RW] ? '1 : a[RW-1:0];
    endfunction

    function automatic logic [CW-1:0] col_clamp(input logic [CW:0] a);
        return a[CW] ? '1 : a[CW-1:0];
    endfunction

    state_t state_q, state_d;
    logic [3:0]    cur_zone_q, cur_zone_d;
    logic [1:0]    zr_q, zr_d, zc_q, zc_d;
    logic [RW:0]   row_base_q, row_base_d;
    logic [CW:0]   col_base_q, col_base_d;
    logic [1:0]    rows_m1_q, rows_m1_d, cols_m1_q, cols_m1_d;
    logic [CW-1:0] org_col_q, org_col_d;
    logic [RW-1:0] zh_q, zh_d;
    logic [CW-1:0] zw_q, zw_d;
    logic [RW-1:0] win_rs_q, win_rs_d, win_re_q, win_re_d;
    logic [CW-1:0] win_cs_q, win_cs_d, win_ce_q, win_ce_d;
    logic [15:0]   zone_valid_q, zone_valid_d;
    logic [ACCUM_WIDTH-1:0] rd_data_q, rd_data_d;
    logic          sweep_done_q, sweep_done_d;
    logic          error_q, error_d;

    logic [ACCUM_WIDTH-1:0] st_acc_q [16][4];
    logic [COUNT_WIDTH-1:0] st_cnt_q [16];

    logic          fs, last_col, last_zone;
    logic [1:0]    nzr, nzc;
    logic [RW:0]   nrb, sel_rb;
    logic [CW:0]   ncb, sel_cb;
    logic          cap_we, load_win, use_next, advance, start, error_set;

    // Geometry of the zone after cur_zone, derived by stepping the running bases.
    always_comb begin
        fs        = dvi && (dtypei == DTYPE_FRAME_START);
        last_col  = (zc_q == cols_m1_q);
        last_zone = last_col && (zr_q == rows_m1_q);
        if (last_col) begin
            nzc = '0;
            ncb = {1'b0, org_col_q};
            nzr = zr_q + 2'd1;
            nrb = row_add(row_base_q, zh_q);
        end else begin
            nzc = zc_q + 2'd1;
            ncb = col_add(col_base_q, zw_q);
            nzr = zr_q;
            nrb = row_base_q;
        end
    end

    // Sequencer next state, zone stepping, window load and sticky error.
    always_comb begin
        state_d      = state_q;
        cur_zone_d   = cur_zone_q;
        zr_d         = zr_q;
        zc_d         = zc_q;
        row_base_d   = row_base_q;
        col_base_d   = col_base_q;
        rows_m1_d    = rows_m1_q;
        cols_m1_d    = cols_m1_q;
        org_col_d    = org_col_q;
        zh_d         = zh_q;
        zw_d         = zw_q;
        win_rs_d     = win_rs_q;
        win_re_d     = win_re_q;
        win_cs_d     = win_cs_q;
        win_ce_d     = win_ce_q;
        zone_valid_d = zone_valid_q;
        sweep_done_d = 1'b0;
        cap_we       = 1'b0;
        load_win     = 1'b0;
        use_next     = 1'b0;
        advance      = 1'b0;
        start        = 1'b0;
        error_set    = 1'b0;
        sel_rb       = row_base_q;
        sel_cb       = col_base_q;

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: start = 1'b1;
                S_ARM: begin
                    if (fs) begin
                        load_win = 1'b1;
                        state_d  = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (mean_done) begin
                        state_d = S_CAPTURE;
                    end else if (fs) begin
                        // Missed zone: the new frame already belongs to the next zone.
                        error_set = 1'b1;
                        if (last_zone) begin
                            sweep_done_d = 1'b1;
                            if (continuous) start = 1'b1;
                            else            state_d = S_IDLE;
                        end else begin
                            advance  = 1'b1;
                            use_next = 1'b1;
                            load_win = 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    cap_we = 1'b1;
                    zone_valid_d[cur_zone_q] = 1'b1;
                    if (last_zone) begin
                        sweep_done_d = 1'b1;
                        if (continuous) start = 1'b1;
                        else            state_d = S_IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = S_ARM;
                    end
                end
            endcase
        end

        if (advance) begin
            cur_zone_d = cur_zone_q + 4'd1;
            zr_d       = nzr;
            zc_d       = nzc;
            row_base_d = nrb;
            col_base_d = ncb;
        end
        // Restart clears zone_valid after any capture set in the same cycle.
        if (start) begin
            state_d      = S_ARM;
            cur_zone_d   = '0;
            zr_d         = '0;
            zc_d         = '0;
            row_base_d   = {1'b0, origin_row};
            col_base_d   = {1'b0, origin_col};
            rows_m1_d    = grid_rows_m1;
            cols_m1_d    = grid_cols_m1;
            org_col_d    = origin_col;
            zh_d         = zone_height;
            zw_d         = zone_width;
            zone_valid_d = '0;
        end
        if (use_next) begin
            sel_rb = nrb;
            sel_cb = ncb;
        end
        if (load_win) begin
            win_rs_d = row_clamp(sel_rb);
            win_re_d = row_clamp(row_add(sel_rb, zh_q));
            win_cs_d = col_clamp(sel_cb);
            win_ce_d = col_clamp(col_add(sel_cb, zw_q));
        end

        error_d = error_q;
        if (error_clr) error_d = 1'b0;
        if (error_set) error_d = 1'b1;
    end

    // Registered result read; the count field is zero-extended.
    always_comb begin
        rd_data_d = '0;
        case (rd_sel)
            3'd0, 3'd1, 3'd2, 3'd3: rd_data_d = st_acc_q[rd_zone][rd_sel[1:0]];
            3'd4:                   rd_data_d = {{(ACCUM_WIDTH-COUNT_WIDTH){1'b0}}, st_cnt_q[rd_zone]};
            default:                rd_data_d = '0;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= S_IDLE;
            cur_zone_q   <= '0;
            zr_q         <= '0;
            zc_q         <= '0;
            row_base_q   <= '0;
            col_base_q   <= '0;
            rows_m1_q    <= '0;
            cols_m1_q    <= '0;
            org_col_q    <= '0;
            zh_q         <= '0;
            zw_q         <= '0;
            win_rs_q     <= '0;
            win_re_q     <= '0;
            win_cs_q     <= '0;
            win_ce_q     <= '0;
            zone_valid_q <= '0;
            rd_data_q    <= '0;
            sweep_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_zone_q   <= cur_zone_d;
            zr_q         <= zr_d;
            zc_q         <= zc_d;
            row_base_q   <= row_base_d;
            col_base_q   <= col_base_d;
            rows_m1_q    <= rows_m1_d;
            cols_m1_q    <= cols_m1_d;
            org_col_q    <= org_col_d;
            zh_q         <= zh_d;
            zw_q         <= zw_d;
            win_rs_q     <= win_rs_d;
            win_re_q     <= win_re_d;
            win_cs_q     <= win_cs_d;
            win_ce_q     <= win_ce_d;
            zone_valid_q <= zone_valid_d;
            rd_data_q    <= rd_data_d;
            sweep_done_q <= sweep_done_d;
            error_q      <= error_d;
        end
    end

    // Result store, written in the capture cycle while image_mean outputs are stable.
    always_ff @(posedge pixclk) begin
        if (cap_we) begin
            st_acc_q[cur_zone_q][0] <= mean_accum00;
            st_acc_q[cur_zone_q][1] <= mean_accum01;
            st_acc_q[cur_zone_q][2] <= mean_accum10;
            st_acc_q[cur_zone_q][3] <= mean_accum11;
            st_cnt_q[cur_zone_q]    <= mean_count;
        end
    end

    assign window_row_start = win_rs_q;
    assign window_row_end   = win_re_q;
    assign window_col_start = win_cs_q;
    assign window_col_end   = win_ce_q;
    assign rd_data          = rd_data_q;
    assign zone_valid       = zone_valid_q;
    assign cur_zone         = cur_zone_q;
    assign sweep_busy       = (state_q != S_IDLE);
    assign sweep_done       = sweep_done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_image_mean_zone_sequencer.sv
// Directed bench for image_mean_zone_sequencer; the bench stands in for
// image_mean, supplying done pulses and ramp-image channel sums.
module tb_image_mean_zone_sequencer;

    localparam int AW = 30;
    localparam int CNW = 22;

    logic          pixclk, resetb, dvi, enable, continuous, mean_done, error_clr;
    logic [3:0]    dtypei;
    logic [1:0]    grid_rows_m1, grid_cols_m1;
    logic [11:0]   origin_row, origin_col, zone_height, zone_width;
    logic [AW-1:0] mean_accum00, mean_accum01, mean_accum10, mean_accum11;
    logic [CNW-1:0] mean_count;
    logic [11:0]   window_row_start, window_row_end, window_col_start, window_col_end;
    logic [3:0]    rd_zone, cur_zone;
    logic [2:0]    rd_sel;
    logic [AW-1:0] rd_data;
    logic [15:0]   zone_valid;
    logic          sweep_busy, sweep_done, error;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_sum [4][4];
    logic [31:0] exp_cnt [4];

    image_mean_zone_sequencer #(
        .PIXEL_WIDTH(8), .NUM_ROWS_WIDTH(12), .NUM_COLS_WIDTH(12),
        .DTYPE_WIDTH(4), .DTYPE_FRAME_START(4'd1)
    ) dut (
        .pixclk(pixclk), .resetb(resetb), .dvi(dvi), .dtypei(dtypei),
        .enable(enable), .continuous(continuous),
        .grid_rows_m1(grid_rows_m1), .grid_cols_m1(grid_cols_m1),
        .origin_row(origin_row), .origin_col(origin_col),
        .zone_height(zone_height), .zone_width(zone_width),
        .mean_done(mean_done),
        .mean_accum00(mean_accum00), .mean_accum01(mean_accum01),
        .mean_accum10(mean_accum10), .mean_accum11(mean_accum11),
        .mean_count(mean_count),
        .window_row_start(window_row_start), .window_row_end(window_row_end),
        .window_col_start(window_col_start), .window_col_end(window_col_end),
        .rd_zone(rd_zone), .rd_sel(rd_sel), .rd_data(rd_data),
        .zone_valid(zone_valid), .cur_zone(cur_zone),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .error(error), .error_clr(error_clr)
    );

    initial begin
        pixclk = 1'b0;
        forever #5 pixclk = ~pixclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic frame_start();
        dvi = 1'b1;
        dtypei = 4'd1;
        tick();
        dvi = 1'b0;
        dtypei = 4'd0;
    endtask

    // Done pulse, then the capture cycle; returns just after capture has registered.
    task automatic mean_report(input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3,
                               input logic [31:0] cnt);
        mean_accum00 = AW'(a0);
        mean_accum01 = AW'(a1);
        mean_accum10 = AW'(a2);
        mean_accum11 = AW'(a3);
        mean_count   = CNW'(cnt);
        mean_done    = 1'b1;
        tick();
        mean_done = 1'b0;
        tick();
    endtask

    // Channel sum over [rs,re) x [cs,ce) of the ramp image pix = (r + 2c) mod 256.
    function automatic logic [31:0] ramp_sum(input int rs, input int re, input int cs,
                                             input int ce, input int ch);
        logic [31:0] s;
        s = 0;
        for (int r = rs; r < re; r++)
            for (int c = cs; c < ce; c++)
                if (((r % 2) * 2 + (c % 2)) == ch) s += 32'((r + 2 * c) % 256);
        return s;
    endfunction

    task automatic check_win(input string tag, input int rs, input int re, input int cs, input int ce);
        check({tag, ".rs"}, 32'(window_row_start), 32'(rs));
        check({tag, ".re"}, 32'(window_row_end),   32'(re));
        check({tag, ".cs"}, 32'(window_col_start), 32'(cs));
        check({tag, ".ce"}, 32'(window_col_end),   32'(ce));
    endtask

    // One zone of the 2x2 sweep at origin (4,8), zone 16x32.
    task automatic run_zone(input int z, input logic last);
        int rs, cs;
        rs = 4 + (z / 2) * 16;
        cs = 8 + (z % 2) * 32;
        frame_start();
        check($sformatf("z%0d.win", z), 0, 0);
        vectors--;
        check_win($sformatf("z%0d", z), rs, rs + 16, cs, cs + 32);
        check($sformatf("z%0d.cur", z), 32'(cur_zone), 32'(z));
        tick();
        tick();
        for (int ch = 0; ch < 4; ch++) exp_sum[z][ch] = ramp_sum(rs, rs + 16, cs, cs + 32, ch);
        exp_cnt[z] = 128;
        mean_report(exp_sum[z][0], exp_sum[z][1], exp_sum[z][2], exp_sum[z][3], 128);
        check($sformatf("z%0d.valid", z), 32'(zone_valid[z]), 1);
        check($sformatf("z%0d.done", z), 32'(sweep_done), 32'(last));
    endtask

    task automatic cfg_2x2();
        grid_rows_m1 = 2'd1; grid_cols_m1 = 2'd1;
        origin_row = 12'd4;  origin_col = 12'd8;
        zone_height = 12'd16; zone_width = 12'd32;
    endtask

    initial begin
        resetb = 1'b0; dvi = 1'b0; dtypei = '0; enable = 1'b0; continuous = 1'b0;
        mean_done = 1'b0; error_clr = 1'b0; rd_zone = '0; rd_sel = '0;
        mean_accum00 = '0; mean_accum01 = '0; mean_accum10 = '0; mean_accum11 = '0;
        mean_count = '0;
        cfg_2x2();
        #13;
        check("rst.win_rs", 32'(window_row_start), 0);
        check("rst.win_ce", 32'(window_col_end), 0);
        check("rst.rd_data", 32'(rd_data), 0);
        check("rst.valid", 32'(zone_valid), 0);
        check("rst.cur", 32'(cur_zone), 0);
        check("rst.busy", 32'(sweep_busy), 0);
        check("rst.done", 32'(sweep_done), 0);
        check("rst.error", 32'(error), 0);
        @(negedge pixclk);
        resetb = 1'b1;
        tick();

        // 2x2 sweep, single shot
        enable = 1'b1;
        tick();
        check("s1.busy", 32'(sweep_busy), 1);
        run_zone(0, 1'b0);
        run_zone(1, 1'b0);
        run_zone(2, 1'b0);
        run_zone(3, 1'b1);
        check("s1.valid_all", 32'(zone_valid), 32'h000F);
        enable = 1'b0;
        tick();
        check("s1.done_off", 32'(sweep_done), 0);
        check("s1.idle_busy", 32'(sweep_busy), 0);
        check("s1.valid_kept", 32'(zone_valid), 32'h000F);
        for (int z = 0; z < 4; z++) begin
            for (int s = 0; s < 5; s++) begin
                rd_zone = 4'(z);
                rd_sel  = 3'(s);
                tick();
                check($sformatf("rd.z%0d.s%0d", z, s), 32'(rd_data),
                      (s == 4) ? exp_cnt[z] : exp_sum[z][s]);
            end
        end
        rd_zone = 4'd1; rd_sel = 3'd6;
        tick();
        check("rd.sel6", 32'(rd_data), 0);

        // continuous 1x1 sweep: done every frame, valid cleared on restart
        grid_rows_m1 = 2'd0; grid_cols_m1 = 2'd0;
        origin_row = 12'd0;  origin_col = 12'd0;
        zone_height = 12'd8; zone_width = 12'd8;
        continuous = 1'b1;
        enable = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            frame_start();
            check_win($sformatf("c%0d", f), 0, 8, 0, 8);
            mean_report(32'h100 + 32'(f), 32'h200, 32'h300, 32'h400, 16);
            check($sformatf("c%0d.done", f), 32'(sweep_done), 1);
            check($sformatf("c%0d.valid", f), 32'(zone_valid), 0);
            check($sformatf("c%0d.busy", f), 32'(sweep_busy), 1);
            tick();
            check($sformatf("c%0d.done_off", f), 32'(sweep_done), 0);
        end
        rd_zone = 4'd0; rd_sel = 3'd0;
        tick();
        check("c.rd_acc00", 32'(rd_data), 32'h102);
        rd_sel = 3'd4;
        tick();
        check("c.rd_cnt", 32'(rd_data), 16);
        enable = 1'b0;
        continuous = 1'b0;
        tick();

        // missed zone: zone 0 never reports done before the next frame start
        grid_rows_m1 = 2'd0; grid_cols_m1 = 2'd1;
        enable = 1'b1;
        tick();
        frame_start();
        check_win("m0", 0, 8, 0, 8);
        frame_start();
        check("m.error", 32'(error), 1);
        check("m.valid0", 32'(zone_valid), 0);
        check("m.cur", 32'(cur_zone), 1);
        check("m.busy", 32'(sweep_busy), 1);
        check_win("m1", 0, 8, 8, 16);
        mean_report(32'h11, 32'h22, 32'h33, 32'h44, 64);
        check("m.valid1", 32'(zone_valid), 32'h0002);
        check("m.done", 32'(sweep_done), 1);
        check("m.error_held", 32'(error), 1);
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        check("m.error_clr", 32'(error), 0);
        enable = 1'b0;
        tick();

        // enable dropped while measuring zone 2 of 4
        cfg_2x2();
        enable = 1'b1;
        tick();
        run_zone(0, 1'b0);
        run_zone(1, 1'b0);
        frame_start();
        check("e.cur", 32'(cur_zone), 2);
        enable = 1'b0;
        tick();
        check("e.busy", 32'(sweep_busy), 0);
        check("e.done", 32'(sweep_done), 0);
        check("e.valid", 32'(zone_valid), 32'h0003);
        check("e.win_held", 32'(window_row_start), 20);
        tick();
        check("e.done_later", 32'(sweep_done), 0);

        // column clamp near the top of the 12-bit range
        grid_rows_m1 = 2'd0; grid_cols_m1 = 2'd1;
        origin_row = 12'd0;  origin_col = 12'd4090;
        zone_height = 12'd8; zone_width = 12'd16;
        enable = 1'b1;
        tick();
        frame_start();
        check_win("k0", 0, 8, 4090, 4095);
        frame_start();
        check_win("k1", 0, 8, 4095, 4095);
        enable = 1'b0;
        tick();
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;

        // asynchronous reset in MEASURE, then restart at zone 0
        cfg_2x2();
        enable = 1'b1;
        tick();
        frame_start();
        check("r.busy_pre", 32'(sweep_busy), 1);
        #2;
        resetb = 1'b0;
        #1;
        check("r.busy", 32'(sweep_busy), 0);
        check("r.win_rs", 32'(window_row_start), 0);
        check("r.win_re", 32'(window_row_end), 0);
        check("r.win_ce", 32'(window_col_end), 0);
        check("r.cur", 32'(cur_zone), 0);
        check("r.valid", 32'(zone_valid), 0);
        check("r.rd_data", 32'(rd_data), 0);
        @(negedge pixclk);
        resetb = 1'b1;
        tick();
        check("r.rearm", 32'(sweep_busy), 1);
        frame_start();
        check_win("r0", 4, 20, 8, 40);
        check("r.cur0", 32'(cur_zone), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
